// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one start/data(LSB first)/[parity]/stop frame per accepted byte,
// bit-timed by a 16x baud_tick. Define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_tick_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_cnt;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_bit_end;

  assign w_bit_end = baud_tick && (r_tick_cnt == TICK_LAST);

  // Each output is registered and updated alongside the state it reflects,
  // so tx/s_ready/busy change on exactly the edge the state does.
  // NOTE: all state uses <= so every register samples pre-edge values, matching flop behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (r_state == ST_IDLE) begin
      r_tick_cnt <= '0;
      if (s_valid) begin
        r_shift    <= s_data;
        r_bit_idx  <= '0;
        r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
        r_parity   <= ^s_data;
`endif
        r_state    <= ST_START;
        r_tx       <= 1'b0;
        r_ready    <= 1'b0;
        r_busy     <= 1'b1;
      end
    end else begin
      if (baud_tick) begin
        r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + IDX_W'(1);
            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_stop_cnt == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_ready;
  assign tx      = r_tx;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frames are compared bit by bit against an expected
// bit list built from the byte; honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_ctrl;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int STOP_BITS  = 2;
  localparam int CLK_DIV    = 3;
  localparam int BIT_CYC    = OVERSAMPLE * CLK_DIV;

  logic                 clk;
  logic                 rst_n;
  logic                 baud_tick;
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 tx;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int tick_cnt;

  uart_tx_ctrl #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_tick(baud_tick),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running baud tick: one-cycle pulse every CLK_DIV cycles, updated just after posedge.
  initial begin
    baud_tick = 1'b0;
    tick_cnt  = int'($urandom_range(0, CLK_DIV - 1));
    forever begin
      @(posedge clk);
      #1;
      tick_cnt  = (tick_cnt == CLK_DIV - 1) ? 0 : tick_cnt + 1;
      baud_tick = (tick_cnt == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: s_valid low during frame; 1: random s_valid/s_data noise; 2: hold s_valid with next_d
  task automatic run_frame(input logic [7:0] d, input int mode, input logic [7:0] next_d);
    logic exp_bits[$];
    int   hs_bad;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) exp_bits.push_back(((d >> i) & 8'd1) != 0);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(($countones(d) % 2) == 1);
`endif
    for (int i = 0; i < STOP_BITS; i++) exp_bits.push_back(1'b1);

    check("idle_ready", s_ready, 1);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    check("hs_tx_fall", tx, 0);
    check("hs_ready_low", s_ready, 0);
    check("hs_busy", busy, 1);
    case (mode)
      0: s_valid = 1'b0;
      2: begin s_valid = 1'b1; s_data = next_d; end
      default: ;
    endcase

    hs_bad = 0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      int   ticks;
      int   len;
      int   glitch;
      logic mid;
      bit   done;
      ticks = 0; len = 0; glitch = 0; mid = 1'bx; done = 0;
      while (!done) begin
        len++;
        if (tx !== exp_bits[b]) glitch++;
        if (s_ready !== 1'b0 || busy !== 1'b1) hs_bad++;
        if (baud_tick) begin
          ticks++;
          if (ticks == OVERSAMPLE / 2) mid = tx;
        end
        if (ticks == OVERSAMPLE) begin
          done = 1;
          if (b == exp_bits.size() - 1 && mode != 2) s_valid = 1'b0;
        end else if (len > (OVERSAMPLE + 1) * CLK_DIV) begin
          done = 1;
        end else if (mode == 1) begin
          s_valid = 1'($urandom_range(0, 1));
          s_data  = 8'($urandom);
        end
        @(negedge clk);
      end
      check("bit_mid", mid, exp_bits[b]);
      check("bit_glitch", glitch, 0);
      if (b == 0)
        check("start_len_in_range",
              32'((len >= (OVERSAMPLE - 1) * CLK_DIV + 1) && (len <= BIT_CYC)), 1);
      else
        check("bit_len", len, BIT_CYC);
    end
    check("frame_ready_busy", hs_bad, 0);
  endtask

  initial begin
    logic [7:0] rd;
    int         ticks;
    int         guard;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_ignores_ticks", tx, 1);

    run_frame(8'hA5, 0, 8'h00);
    repeat (3) @(negedge clk);

    run_frame(8'h00, 2, 8'hFF);
    run_frame(8'hFF, 0, 8'h00);
    repeat (2) @(negedge clk);

    run_frame(8'h07, 1, 8'h00);
    run_frame(8'h03, 0, 8'h00);
    repeat (4) @(negedge clk);

    run_frame(8'h55, 0, 8'h00);
    @(negedge clk);

    // Abandon 0x3C halfway through data bit 3 with an asynchronous reset.
    s_data  = 8'h3C;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    ticks   = 0;
    guard   = 0;
    while (ticks < 4 * OVERSAMPLE + OVERSAMPLE / 2 && guard < 10 * BIT_CYC) begin
      if (baud_tick) ticks++;
      guard++;
      @(negedge clk);
    end
    check("pre_rst_busy", busy, 1);
    check("pre_rst_tx_bit3", tx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_ready", s_ready, 1);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'h81, 0, 8'h00);

    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      rd = 8'($urandom);
      run_frame(rd, int'($urandom_range(0, 1)), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
